bsg_mem_1rw_sync_mask_write_rmw: RTL
====================================

Name: bsg_mem_1rw_sync_mask_write_rmw

Overview:
- Single-port synchronous memory with a write mask of parametrised granularity (any divisor of width_p, not just bytes).
- Built on one full-width, non-maskable 1RW storage array.
- Partial-mask writes run as an internal two-cycle read-modify-write (RMW); full-mask writes and reads take one cycle.
- Intended for SRAM macros that lack bit/byte enables; sits behind cache data arrays and scratchpads that need sub-word stores.

Parameters:
- width_p, 32: data word width in bits; must be >0 and a multiple of mask_gran_p.
- els_p, 64: number of words; must be >0.
- mask_gran_p, 8: bits controlled by each mask bit.
- latch_last_read_p, 0: 1 = data_o holds the last read word until the next read completes.
- addr_width_lp, derived, safe clog2 of els_p.
- mask_width_lp, derived, width_p/mask_gran_p.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  asynchronous, active-high reset.
- v_i  in  1  request valid.
- ready_o  out  1  block accepts a request this cycle; a request is accepted when v_i & ready_o.
- w_i  in  1  1 = write, 0 = read.
- addr_i  in  addr_width_lp  word address.
- data_i  in  width_p  write data.
- write_mask_i  in  mask_width_lp  bit k=1 writes data_i[k*mask_gran_p +: mask_gran_p].
- data_v_o  out  1  data_o valid for a read accepted in the previous cycle.
- data_o  out  width_p  read data.

Behaviour:
- Reset (async assert, sync deassert): FSM to IDLE; ready_o=1, data_v_o=0, data_o=0. Array contents are not reset.
- FSM states: IDLE and MERGE.
- IDLE, accepted read: array read issued; the next cycle data_v_o=1 and data_o=mem[addr]. FSM stays IDLE.
- IDLE, accepted write with write_mask_i all ones: direct one-cycle array write. ready_o stays 1. data_v_o=0 next cycle.
- IDLE, accepted write with mask all zeros: no array access, no state change. ready_o stays 1.
- IDLE, accepted write with a partial mask:
  - The array is read at addr_i.
  - addr, data and mask are captured into holding registers.
  - FSM goes to MERGE.
- MERGE:
  - ready_o=0; v_i is ignored, and requesters must hold their request.
  - Array written at the held addr with merged = (rdata & ~expanded_mask) | (held_data & expanded_mask), where expanded_mask replicates each mask bit mask_gran_p times.
  - Next state IDLE. data_v_o=0 during and after MERGE.
- The RMW read never raises data_v_o and never updates data_o.
- Throughput: one request per cycle, except partial writes, which cost two cycles.
- Ordering: a read accepted the cycle after MERGE returns the merged value. The array is written at the MERGE edge, so no forwarding is needed.
- latch_last_read_p=0: data_o is defined only when data_v_o=1; the bench must not check it otherwise.
- latch_last_read_p=1: data_o holds the last read result across writes, RMWs and idle cycles.
- Reset asserted during MERGE: the write is aborted; mem[addr] keeps its old value; FSM returns to IDLE.
- Out-of-range addr (els_p not a power of two): undefined; an assertion flags it.
- ready_o depends only on FSM state, never combinationally on v_i.
- Elaboration errors: width_p % mask_gran_p != 0, or mask_gran_p == 0.

Decomposition:
- Shared package: FSM state enum (e_rmw_idle, e_rmw_merge); mask-expansion helper function (mask, granularity -> bit mask).
- Sub-module: the existing full-width synchronous 1RW storage array (bsg_mem_1rw_sync_synth), instantiated once at width_p x els_p.
- The wrapper contains the FSM, holding registers, merge datapath and output latch.

Test Plan:
1. Reset check: reset mid-run -> ready_o=1, data_v_o=0, data_o=0, FSM in IDLE.
2. Full writes then reads (width_p=32, gran 8): write 0xDEADBEEF to addr 5 with mask 4'b1111; read addr 5 -> next cycle data_v_o=1, data_o=0xDEADBEEF; ready_o never drops.
3. Partial RMW: from the state in test 2, write 0x11223344 to addr 5 with mask 4'b0101 -> ready_o=0 for exactly one cycle; a following read returns 0xDE22BE44.
4. Back-to-back partial writes: hold v_i high with two partial writes to different addresses -> each accepted in turn, ready_o pattern 1,0,1,0; both words merge correctly; v_i during MERGE is not consumed.
5. Granularity sweep (gran 4, width 16): write 0xABCD, then mask 4'b1000 with data 0x0000 -> read returns 0x0BCD. Zero mask -> no change and no stall.
6. Abort: assert reset_i during MERGE of a write to addr 3 (old value 0x0, mask 4'b0011, data 0xFFFF) -> after reset, a read of addr 3 returns 0x0. With latch_last_read_p=1, data_o holds the last read value across the RMW and idle cycles.

Source files
------------

// File: rtl/bsg_mem_1rw_sync_mask_write_rmw_pkg.sv
// bsg_mem_1rw_sync_mask_write_rmw_pkg: RMW FSM state encoding and write-mask expansion helper.
package bsg_mem_1rw_sync_mask_write_rmw_pkg;

   typedef enum logic {e_rmw_idle, e_rmw_merge} rmw_state_e;

   localparam int max_width_gp = 1024;

   // Replicates each mask bit gran times; callers truncate to their own width.
   function automatic logic [max_width_gp-1:0] expand_mask(input logic [max_width_gp-1:0] mask,
                                                           input int unsigned gran);
      logic [max_width_gp-1:0] r;
      r = '0;
      if (gran != 0)
         for (int i = 0; i < max_width_gp; i++) r[i] = mask[i / gran];
      return r;
   endfunction

endpackage

// File: rtl/bsg_mem_1rw_sync_synth.sv
// bsg_mem_1rw_sync_synth: full-width single-port synchronous array; data_o updates only on reads.
module bsg_mem_1rw_sync_synth #(
   parameter int width_p       = 32,
   parameter int els_p         = 64,
   parameter int addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1
) (
   input  logic                     clk_i,
   input  logic                     v_i,
   input  logic                     w_i,
   input  logic [addr_width_lp-1:0] addr_i,
   input  logic [width_p-1:0]       data_i,
   output logic [width_p-1:0]       data_o
);

   logic [width_p-1:0] mem [els_p];

   always_ff @(posedge clk_i)
      if (v_i & w_i) mem[addr_i] <= data_i;
      else if (v_i) data_o <= mem[addr_i];

endmodule

// File: rtl/bsg_mem_1rw_sync_mask_write_rmw.sv
// bsg_mem_1rw_sync_mask_write_rmw: masked-write memory over a non-maskable array;
// partial masks become a two-cycle read-modify-write.
module bsg_mem_1rw_sync_mask_write_rmw
   import bsg_mem_1rw_sync_mask_write_rmw_pkg::*;
#(
   parameter int width_p           = 32,
   parameter int els_p             = 64,
   parameter int mask_gran_p       = 8,
   parameter int latch_last_read_p = 0,
   parameter int addr_width_lp     = (els_p > 1) ? $clog2(els_p) : 1,
   parameter int mask_width_lp     = (mask_gran_p == 0) ? 1 : width_p / mask_gran_p
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic                     v_i,
   output logic                     ready_o,
   input  logic                     w_i,
   input  logic [addr_width_lp-1:0] addr_i,
   input  logic [width_p-1:0]       data_i,
   input  logic [mask_width_lp-1:0] write_mask_i,
   output logic                     data_v_o,
   output logic [width_p-1:0]       data_o
);

   if (mask_gran_p <= 0) begin : g_err_gran
      $error("mask_gran_p must be positive");
   end else if (width_p % mask_gran_p != 0) begin : g_err_div
      $error("width_p must be a multiple of mask_gran_p");
   end
   if (width_p > max_width_gp) begin : g_err_width
      $error("width_p exceeds max_width_gp");
   end

   rmw_state_e               state_r, state_n;
   logic [addr_width_lp-1:0] addr_r, mem_addr;
   logic [width_p-1:0]       data_r, mem_wdata, mem_rdata, mask_bits, merged;
   logic [mask_width_lp-1:0] mask_r;
   logic                     accept, full_mask, zero_mask, partial;
   logic                     mem_v, mem_w, read_pending_r;

   assign ready_o   = (state_r == e_rmw_idle);
   assign accept    = v_i & ready_o & ~reset_i;
   assign full_mask = &write_mask_i;
   assign zero_mask = ~|write_mask_i;
   assign partial   = accept & w_i & ~full_mask & ~zero_mask;
   assign data_v_o  = read_pending_r;

   // The array output still holds the RMW read during MERGE, since nothing else reads it.
   assign mask_bits = width_p'(expand_mask(max_width_gp'(mask_r), mask_gran_p));
   assign merged    = (mem_rdata & ~mask_bits) | (data_r & mask_bits);

   always_ff @(posedge clk_i or posedge reset_i)
      if (reset_i) state_r <= e_rmw_idle;
      else state_r <= state_n;

   always_comb begin
      state_n = partial ? e_rmw_merge : e_rmw_idle;
   end

   always_comb begin
      mem_v     = ready_o ? (accept & ~(w_i & zero_mask)) : 1'b1;
      mem_w     = ready_o ? (w_i & full_mask) : 1'b1;
      mem_addr  = ready_o ? addr_i : addr_r;
      mem_wdata = ready_o ? data_i : merged;
   end

   always_ff @(posedge clk_i)
      if (partial) begin
         addr_r <= addr_i;
         data_r <= data_i;
         mask_r <= write_mask_i;
      end

   always_ff @(posedge clk_i or posedge reset_i)
      if (reset_i) read_pending_r <= 1'b0;
      else read_pending_r <= accept & ~w_i;

   if (latch_last_read_p != 0) begin : g_latch
      logic [width_p-1:0] last_r;
      always_ff @(posedge clk_i or posedge reset_i)
         if (reset_i) last_r <= '0;
         else if (read_pending_r) last_r <= mem_rdata;
      assign data_o = read_pending_r ? mem_rdata : last_r;
   end else begin : g_no_latch
      assign data_o = read_pending_r ? mem_rdata : '0;
   end

   if ((1 << addr_width_lp) != els_p) begin : g_addr_chk
      always_ff @(posedge clk_i)
         if (accept) assert (32'(addr_i) < els_p);
   end

   bsg_mem_1rw_sync_synth #(
      .width_p (width_p),
      .els_p   (els_p)
   ) mem_array (
      .clk_i  (clk_i),
      .v_i    (mem_v),
      .w_i    (mem_w),
      .addr_i (mem_addr),
      .data_i (mem_wdata),
      .data_o (mem_rdata)
   );

endmodule
